// File: rtl/dice_roll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dice_pkg
//  Description : Shared types and constants for the electronic-dice roll
//                sequencer (state encoding, throw width and legal range).
//  Revision    : 1.0 - initial release
// ============================================================================
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLL    = 2'd1,
        SETTLE  = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam int                 THROW_W   = 3;
    localparam logic [THROW_W-1:0] THROW_MIN = 3'd1;
    localparam logic [THROW_W-1:0] THROW_MAX = 3'd6;

    // A dice face is only meaningful in 1..6; 0 and 7 mean the counter glitched.
    function automatic logic is_legal_throw(input logic [THROW_W-1:0] t);
        return (t >= THROW_MIN) && (t <= THROW_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dice_roll_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dice_roll_ctrl_if
//  Description : Bundle of the button pin, dice-counter link and result
//                valid/ready offer seen by the roll sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dice_roll_ctrl_if #(
    parameter int CNT_W = 8
) ();
    logic                        button;
    logic [dice_pkg::THROW_W-1:0] throw;
    logic                        dice_en;
    logic                        dice_button;
    logic [dice_pkg::THROW_W-1:0] result;
    logic                        result_valid;
    logic                        result_ready;
    logic                        busy;
    logic [CNT_W-1:0]            roll_count;

    // Sequencer side
    modport master (
        input  button, throw, result_ready,
        output dice_en, dice_button, result, result_valid, busy, roll_count
    );

    // Environment side (button pin, dice counter, downstream consumer)
    modport slave (
        output button, throw, result_ready,
        input  dice_en, dice_button, result, result_valid, busy, roll_count
    );
endinterface
`default_nettype wire

// File: rtl/dice_roll_ctrl_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Two-flop synchroniser followed by a run-length debouncer.
//                o_btn_db flips after DEBOUNCE_CYCLES consecutive synchronised
//                samples that disagree with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_button,
    output logic      o_btn_db
);
    localparam int                    CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;

    // Synchronise the raw pin, then count a run of samples opposite to r_db.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b00;
            r_cnt  <= '0;
            r_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_button};
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_db  <= ~r_db;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_btn_db = r_db;
endmodule
`default_nettype wire

// File: rtl/dice_roll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dice_roll_ctrl
//  Description : Electronic-dice sequencer. Rolls while the button is held
//                (minimum MIN_ROLL_CYCLES), slows down over SETTLE_STEPS
//                widening gaps, latches the throw and offers it valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_ROLL_CYCLES = 8,
    parameter int SETTLE_STEPS    = 6,
    parameter int CNT_W           = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dice_roll_ctrl_if.master bus
);
    localparam int                TMR_W         = $clog2(MIN_ROLL_CYCLES + 1);
    localparam int                STEP_W        = $clog2(SETTLE_STEPS + 2);
    localparam logic [TMR_W-1:0]  c_TMR_MAX     = TMR_W'(MIN_ROLL_CYCLES);
    localparam logic [STEP_W-1:0] c_LAST_STEP   = STEP_W'(SETTLE_STEPS);
    localparam logic [STEP_W-1:0] c_SAMPLE_STEP = STEP_W'(SETTLE_STEPS + 1);
    localparam logic [STEP_W-1:0] c_FIRST_STEP  = STEP_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX     = '1;

    logic w_btn_db;

    state_t             r_state,  w_state_nxt;
    logic [TMR_W-1:0]   r_timer,  w_timer_nxt;
    logic [STEP_W-1:0]  r_step,   w_step_nxt;
    logic [STEP_W-1:0]  r_gap,    w_gap_nxt;
    logic [THROW_W-1:0] r_result, w_result_nxt;
    logic [CNT_W-1:0]   r_count,  w_count_nxt;
    logic               r_db_prev;
    logic               r_dice_en,  w_dice_en_nxt;
    logic               r_dice_btn, w_dice_btn_nxt;
    logic               r_valid,    w_valid_nxt;
    logic               r_busy,     w_busy_nxt;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .i_button (bus.button),
        .o_btn_db (w_btn_db)
    );

    // Next-state logic; outputs are derived from the next state so the
    // registered outputs line up exactly with the state they describe.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_step_nxt   = r_step;
        w_gap_nxt    = r_gap;
        w_result_nxt = r_result;
        w_count_nxt  = r_count;
        case (r_state)
            IDLE: begin
                // Only a fresh edge starts a roll; a button still held from
                // PRESENT has already been seen by r_db_prev.
                if (w_btn_db && !r_db_prev) begin
                    w_state_nxt = ROLL;
                    w_timer_nxt = '0;
                    w_step_nxt  = c_FIRST_STEP;
                    w_gap_nxt   = '0;
                end
            end
            ROLL: begin
                if (r_timer != c_TMR_MAX) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
                if (!w_btn_db && (r_timer >= c_TMR_MAX)) begin
                    w_state_nxt = SETTLE;
                    w_step_nxt  = c_FIRST_STEP;
                    w_gap_nxt   = '0;
                end
            end
            SETTLE: begin
                if (r_step == c_SAMPLE_STEP) begin
                    // Cycle after the last slow-down pulse: take or retry.
                    w_step_nxt = c_FIRST_STEP;
                    w_gap_nxt  = '0;
                    if (is_legal_throw(bus.throw)) begin
                        w_result_nxt = bus.throw;
                        w_state_nxt  = PRESENT;
                    end else begin
                        w_state_nxt = ROLL;
                        w_timer_nxt = '0;
                    end
                end else if (r_gap == r_step) begin
                    // Pulse cycle closes step r_step after r_step idle cycles.
                    w_gap_nxt  = '0;
                    w_step_nxt = (r_step == c_LAST_STEP) ? c_SAMPLE_STEP
                                                         : r_step + 1'b1;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            PRESENT: begin
                if (r_valid && bus.result_ready) begin
                    w_state_nxt = IDLE;
                    if (r_count != c_CNT_MAX) begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_dice_en_nxt  = (w_state_nxt == ROLL) || (w_state_nxt == SETTLE);
        w_dice_btn_nxt = (w_state_nxt == ROLL) ||
                         ((w_state_nxt == SETTLE) && (w_gap_nxt == w_step_nxt));
        w_valid_nxt    = (w_state_nxt == PRESENT);
        w_busy_nxt     = (w_state_nxt != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_step     <= '0;
            r_gap      <= '0;
            r_result   <= '0;
            r_count    <= '0;
            r_db_prev  <= 1'b0;
            r_dice_en  <= 1'b0;
            r_dice_btn <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_step     <= w_step_nxt;
            r_gap      <= w_gap_nxt;
            r_result   <= w_result_nxt;
            r_count    <= w_count_nxt;
            r_db_prev  <= w_btn_db;
            r_dice_en  <= w_dice_en_nxt;
            r_dice_btn <= w_dice_btn_nxt;
            r_valid    <= w_valid_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.dice_en      = r_dice_en;
    assign bus.dice_button  = r_dice_btn;
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign bus.busy         = r_busy;
    assign bus.roll_count   = r_count;
endmodule
`default_nettype wire
